fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side consumer stage that sits directly downstream of the async FIFO, in the clk_r domain.
- Converts the FIFO's empty/ren/rdata interface (1-cycle registered read latency) into a valid/ready stream with no bubbles.
- Prefetches into a small local buffer, so fifo_ren never depends combinationally on out_ready.
- Provides a synchronous flush that discards buffered and in-flight words.

Parameters:
WIDTH_FIFO, 8, data width; must match the FIFO.
BUF_DEPTH, 3, local prefetch buffer entries; legal range 2..8; 3 or more is needed for 1 word/cycle throughput.
BUF_AW, 2, buffer pointer width, ceil(log2(BUF_DEPTH)); count register is BUF_AW+1 bits.

Ports:
clk_r  input  1  read-domain clock; all logic on posedge.
rst  input  1  reset: one clock; reset is synchronous and active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  WIDTH_FIFO  FIFO read data; valid the cycle after fifo_ren was high.
fifo_ren  output  1  FIFO read enable.
out_valid  output  1  stream word available.
out_data  output  WIDTH_FIFO  stream data; head of buffer.
out_ready  input  1  downstream accept.
flush  input  1  synchronous discard of all held and in-flight data.

Behaviour:
- Reset (rst=1 at a posedge): cnt=0, rd/wr pointers=0, inflight=0. out_valid=0, fifo_ren=0. out_data is don't-care but driven 0 via the buffer mux.
- inflight: register, set to fifo_ren each cycle. Marks that fifo_rdata is valid this cycle.
- fifo_ren = !fifo_empty && !flush && (cnt + inflight < BUF_DEPTH). Registered state and fifo_empty only; no out_ready term.
- push = inflight && !flush. On push, fifo_rdata is written at wr_ptr and wr_ptr is incremented.
- pop = out_valid && out_ready. On pop, rd_ptr is incremented.
- Pointer wrap: pointers wrap modulo BUF_DEPTH, handled explicitly, not by power-of-2 overflow.
- cnt update: cnt_next = cnt + push - pop. Simultaneous push and pop leaves cnt unchanged.
- out_valid = (cnt != 0). out_data = buf[rd_ptr]. There is no bypass, so the first word appears 2 cycles after fifo_ren.
- Buffer fill levels:
  - EMPTY (cnt=0): out_valid=0.
  - PARTIAL: normal operation.
  - FULL (cnt=BUF_DEPTH): fifo_ren=0, guaranteed by the credit rule. A push into a full buffer is impossible by construction and is asserted in simulation.
- Throughput: with BUF_DEPTH>=3, out_ready held high and FIFO non-empty, out_valid is continuously high after a 2-cycle startup.
- out_ready low: the buffer fills to BUF_DEPTH, then fifo_ren drops. No words are lost and order is preserved.
- flush=1 at a posedge:
  - cnt, pointers and inflight are cleared.
  - A word returning from the FIFO that cycle is dropped.
  - fifo_ren is forced 0 that cycle.
  - out_valid is 0 the following cycle.
  - A pop in the flush cycle is still counted as accepted by downstream; its word is gone either way.
- rst has priority over flush.
- FIFO empty deasserting mid-stream: fifo_ren resumes the same cycle fifo_empty=0, provided credits are available.

Optional Feature:
FIFO_RD_CNT_EN
- Defined: adds output rd_cnt [15:0], a count of pops that saturates at 16'hFFFF. It is cleared by rst and by flush.
- Not defined: no rd_cnt port, and no counter logic exists.

Decomposition:
- Shared package fifo_pkg:
  - WIDTH_FIFO and ADDR_FIFO defaults, shared with the async FIFO.
  - BUF_DEPTH default.
  - Rd-counter width constant (16).
- Sub-module fifo_rd_skid_buf: a circular buffer with push/pop/flush/cnt and head-data output, parameterised by WIDTH_FIFO/BUF_DEPTH.
- The top holds the credit, inflight and fifo_ren logic plus the optional counter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with fifo_empty=1 -> fifo_ren=0, out_valid=0, cnt=0.
2. Streaming: FIFO model preloaded with 0x01..0x10, out_ready=1 -> fifo_ren first high at cycle 0, out_valid from cycle 2, 16 consecutive words 0x01..0x10 with no gaps.
3. Backpressure: out_ready=0 with 10 words available -> exactly 3 fifo_ren pulses, cnt=3, out_data=0x01 held stable. Release out_ready -> remaining words arrive in order with no loss or duplication.
4. Simultaneous push/pop at FULL boundary: cnt=3, out_ready pulsed 1 cycle -> one pop, fifo_ren high the next cycle, cnt returns to 3, order preserved.
5. Flush with in-flight read: flush asserted the cycle after fifo_ren with cnt=2 -> cycle after flush out_valid=0, cnt=0, the in-flight word is never output, and the next word output is the FIFO's next entry.
6. FIFO_RD_CNT_EN: 5 pops then flush then 2 pops -> rd_cnt reads 5, then 0, then 2. Preloading the counter near 16'hFFFF (force) -> holds at 16'hFFFF.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO and its read-side stream stage.
//   DEF_WIDTH_FIFO : data width shared with the FIFO
//   DEF_ADDR_FIFO  : FIFO address width shared with the FIFO
//   DEF_BUF_DEPTH  : default prefetch buffer depth of fifo_rd_stream
//   DEF_BUF_AW     : pointer width for DEF_BUF_DEPTH
//   RD_CNT_W       : width of the optional pop counter (FIFO_RD_CNT_EN)
package fifo_pkg;

    localparam int unsigned DEF_WIDTH_FIFO = 8;
    localparam int unsigned DEF_ADDR_FIFO  = 4;
    localparam int unsigned DEF_BUF_DEPTH  = 3;
    localparam int unsigned DEF_BUF_AW     = 2;
    localparam int unsigned RD_CNT_W       = 16;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular prefetch buffer with push/pop/flush and head-of-buffer output.
// Ports:
//   clk_r, rst : clock and synchronous active-high reset
//   flush_i    : clear count and pointers (stored words become unreachable)
//   push_i     : write wdata_i at the tail
//   pop_i      : advance the head
//   cnt_o      : number of words held (0..BUF_DEPTH)
//   head_o     : word at the head pointer
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH_FIFO = DEF_WIDTH_FIFO,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int unsigned BUF_AW     = DEF_BUF_AW
) (
    input  logic                  clk_r,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [WIDTH_FIFO-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [BUF_AW:0]       cnt_o,
    output logic [WIDTH_FIFO-1:0] head_o
);

    localparam int unsigned CNT_W = BUF_AW + 1;

    logic [WIDTH_FIFO-1:0] mem_q [BUF_DEPTH];
    logic [BUF_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Non-power-of-2 depths need an explicit wrap back to zero.
    function automatic logic [BUF_AW-1:0] ptr_inc(input logic [BUF_AW-1:0] p);
        return (32'(p) == BUF_DEPTH - 1) ? '0 : p + BUF_AW'(1);
    endfunction

    // Pointer and fill-count next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // State and storage; storage is cleared on reset so the head reads 0.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
        // The credit rule in the parent must never let a word land in a full buffer.
        if (!rst && push_i && !flush_i) assert (cnt_q != CNT_W'(BUF_DEPTH));
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: turns the empty/ren/rdata interface
// (1-cycle read latency) into a bubble-free valid/ready stream through a
// small prefetch buffer, with synchronous flush.
// Optional macro FIFO_RD_CNT_EN adds rd_cnt, a saturating pop counter.
// Ports:
//   clk_r, rst  : read clock, synchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_rdata  : FIFO data, valid the cycle after fifo_ren
//   fifo_ren    : FIFO read enable (no combinational path from out_ready)
//   out_valid   : stream word available
//   out_data    : head of the prefetch buffer
//   out_ready   : downstream accept
//   flush       : discard all buffered and in-flight words
//   rd_cnt      : pops since reset/flush, saturating (FIFO_RD_CNT_EN only)
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH_FIFO = DEF_WIDTH_FIFO,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int unsigned BUF_AW     = DEF_BUF_AW
) (
    input  logic                  clk_r,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [WIDTH_FIFO-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  out_valid,
    output logic [WIDTH_FIFO-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [RD_CNT_W-1:0]   rd_cnt
`endif
);

    // One spare bit so cnt + inflight cannot overflow the compare.
    localparam int unsigned CW = BUF_AW + 2;

    logic              inflight_q, inflight_d;
    logic              push, pop;
    logic [BUF_AW:0]   buf_cnt;
    logic [CW-1:0]     credit_used;

    // Credit-based read issue: words held plus the word in flight must fit.
    always_comb begin
        credit_used = CW'(buf_cnt) + CW'(inflight_q);
        fifo_ren    = !rst && !fifo_empty && !flush && (credit_used < CW'(BUF_DEPTH));
        inflight_d  = fifo_ren;
        push        = inflight_q && !flush;
        pop         = out_valid && out_ready;
    end

    always_ff @(posedge clk_r) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= inflight_d;
    end

    fifo_rd_skid_buf #(
        .WIDTH_FIFO (WIDTH_FIFO),
        .BUF_DEPTH  (BUF_DEPTH),
        .BUF_AW     (BUF_AW)
    ) u_buf (
        .clk_r   (clk_r),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (fifo_rdata),
        .pop_i   (pop),
        .cnt_o   (buf_cnt),
        .head_o  (out_data)
    );

    assign out_valid = (buf_cnt != '0);

`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    // Saturating pop counter; flush clears it even if a pop coincides.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (flush)                        rd_cnt_d = '0;
        else if (pop && rd_cnt_q != '1)   rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    end

    always_ff @(posedge clk_r) begin
        if (rst) rd_cnt_q <= '0;
        else     rd_cnt_q <= rd_cnt_d;
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model with 1-cycle read latency, a cycle
// table for reset/streaming timing, hand-written backpressure/full/flush
// sequences, a random phase, and a scoreboard of words loaded into the FIFO.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int unsigned W = DEF_WIDTH_FIFO;

    logic         clk_r = 1'b0;
    logic         rst, fifo_empty, fifo_ren, out_valid, out_ready, flush;
    logic [W-1:0] fifo_rdata = '0;
    logic [W-1:0] out_data;
`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_cnt;
`endif

    always #5 clk_r = ~clk_r;

    fifo_rd_stream dut (
        .clk_r      (clk_r),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush      (flush)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt)
`endif
    );

    // FIFO model: storage written by the stimulus, read with 1-cycle latency.
    logic [W-1:0] fmem [0:255];
    int unsigned  wr_idx = 0;
    int unsigned  rd_idx = 0;
    logic         hold_empty;

    always_comb fifo_empty = hold_empty || (rd_idx == wr_idx);

    always @(posedge clk_r) begin
        if (fifo_ren) begin
            fifo_rdata <= fmem[rd_idx[7:0]];
            rd_idx     <= rd_idx + 1;
        end
    end

    // Scoreboard and counters.
    logic [W-1:0] exp_q [$];
    int unsigned  ren_total = 0;
    int unsigned  pop_total = 0;
    int           n_vec = 0;
    int           n_err = 0;

    typedef struct {
        string      name;
        logic       rst, hold, ready, flush;
        logic       exp_ren, exp_valid, chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(string n, logic r, logic h, logic rd, logic f,
                                logic er, logic ev, logic cd, logic [7:0] d);
        vec_t v;
        v.name = n; v.rst = r; v.hold = h; v.ready = rd; v.flush = f;
        v.exp_ren = er; v.exp_valid = ev; v.chk_data = cd; v.exp_data = d;
        return v;
    endfunction

    task chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task load(input logic [W-1:0] v);
        fmem[wr_idx[7:0]] = v;
        wr_idx++;
        exp_q.push_back(v);
    endtask

    // Sampled at negedge: inputs and state are stable for the next posedge.
    task monitor_sample();
        logic [W-1:0] e;
        if (!rst) begin
            if (fifo_ren) begin
                ren_total++;
                n_vec++;
                if (fifo_empty) begin
                    n_err++;
                    $display("FAIL ren_while_empty got fifo_ren=1 expected 0");
                end
            end
            if (out_valid && out_ready) begin
                pop_total++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra got %02h expected no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_err++;
                        $display("FAIL stream_data got %02h expected %02h", out_data, e);
                    end
                end
            end
            // Every word read from the FIFO but not yet accepted is discarded.
            if (flush) begin
                while (ren_total > pop_total) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    pop_total++;
                end
            end
        end
    endtask

    task tick();
        @(negedge clk_r);
        monitor_sample();
        @(posedge clk_r);
        #1;
    endtask

    task drain(input string name, input int max);
        int k;
        k = 0;
        while (k < max && !(exp_q.size() == 0 && !out_valid)) begin
            tick();
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL %s_timeout got %0d words left expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; hold_empty = 1'b1; out_ready = 1'b0; flush = 1'b0;

        // Reset, idle, then 16-word stream with exact cycle timing.
        tbl.push_back(mk("rst",   1, 1, 0, 0, 0, 0, 1, 8'h00));
        tbl.push_back(mk("idle0", 0, 1, 0, 0, 0, 0, 1, 8'h00));
        tbl.push_back(mk("idle1", 0, 1, 0, 0, 0, 0, 1, 8'h00));
        for (int c = 0; c < 20; c++) begin
            tbl.push_back(mk($sformatf("stream%0d", c), 0, 0, 1, 0,
                             logic'(c < 16), logic'(c >= 2 && c <= 17),
                             logic'(c >= 2 && c <= 17), 8'(c - 1)));
        end
        for (int i = 1; i <= 16; i++) load(8'(i));

        @(posedge clk_r);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; hold_empty = tbl[i].hold;
            out_ready = tbl[i].ready; flush = tbl[i].flush;
            @(negedge clk_r);
            chk({tbl[i].name, "_ren"},   int'(fifo_ren),  int'(tbl[i].exp_ren));
            chk({tbl[i].name, "_valid"}, int'(out_valid), int'(tbl[i].exp_valid));
            if (tbl[i].chk_data) chk({tbl[i].name, "_data"}, int'(out_data), int'(tbl[i].exp_data));
            monitor_sample();
            @(posedge clk_r);
            #1;
        end
        chk("stream_all_out", exp_q.size(), 0);

        // Backpressure: 10 words, downstream stalled.
        begin
            int unsigned r0;
            hold_empty = 1'b1; out_ready = 1'b0;
            for (int i = 0; i < 10; i++) load(8'(8'h21 + i));
            hold_empty = 1'b0;
            r0 = ren_total;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk_r);
                if (k >= 2) begin
                    chk("bp_valid", int'(out_valid), 1);
                    chk("bp_head",  int'(out_data), 'h21);
                end
                monitor_sample();
                @(posedge clk_r);
                #1;
            end
            chk("bp_ren_pulses", int'(ren_total - r0), 3);
            chk("bp_cnt", int'(dut.buf_cnt), 3);
        end

        // Single-cycle pop at FULL: credit frees, refill restores cnt=3.
        out_ready = 1'b1;
        @(negedge clk_r);
        chk("full_ren_blocked", int'(fifo_ren), 0);
        monitor_sample();
        @(posedge clk_r); #1;
        out_ready = 1'b0;
        @(negedge clk_r);
        chk("full_refill_ren", int'(fifo_ren), 1);
        chk("full_head_next",  int'(out_data), 'h22);
        monitor_sample();
        @(posedge clk_r); #1;
        @(negedge clk_r);
        chk("full_ren_inflight", int'(fifo_ren), 0);
        monitor_sample();
        @(posedge clk_r); #1;
        @(negedge clk_r);
        chk("full_cnt_back", int'(dut.buf_cnt), 3);
        chk("full_head_hold", int'(out_data), 'h22);
        monitor_sample();
        @(posedge clk_r); #1;
        out_ready = 1'b1;
        drain("bp_release", 40);

        // Flush with a read in flight and two words buffered.
        hold_empty = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'(8'h41 + i));
        hold_empty = 1'b0;
        tick(); tick(); tick();
        flush = 1'b1;
        @(negedge clk_r);
        chk("flush_ren_forced", int'(fifo_ren), 0);
        chk("flush_cnt_before", int'(dut.buf_cnt), 2);
        monitor_sample();
        @(posedge clk_r); #1;
        flush = 1'b0;
        @(negedge clk_r);
        chk("flush_valid_after", int'(out_valid), 0);
        chk("flush_cnt_after",   int'(dut.buf_cnt), 0);
        chk("flush_ren_resume",  int'(fifo_ren), 1);
        monitor_sample();
        @(posedge clk_r); #1;
        out_ready = 1'b1;
        drain("flush_tail", 40);

        // Random ready, empty toggling and occasional flush.
        for (int i = 0; i < 60; i++) load(8'($urandom_range(0, 255)));
        for (int k = 0; k < 150; k++) begin
            out_ready  = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; hold_empty = 1'b0; out_ready = 1'b1;
        drain("random", 200);

`ifdef FIFO_RD_CNT_EN
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'h61 + i));
        drain("cnt5", 40);
        chk("rd_cnt_5", int'(rd_cnt), 5);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("rd_cnt_flush", int'(rd_cnt), 0);
        for (int i = 0; i < 2; i++) load(8'(8'h71 + i));
        drain("cnt2", 40);
        chk("rd_cnt_2", int'(rd_cnt), 2);
        force dut.rd_cnt_q = 16'hFFFD;
        @(posedge clk_r); #1;
        release dut.rd_cnt_q;
        for (int i = 0; i < 5; i++) load(8'(8'h81 + i));
        drain("cntsat", 40);
        chk("rd_cnt_sat", int'(rd_cnt), 'hFFFF);
`endif

        chk("end_cnt", int'(dut.buf_cnt), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
